// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: applies a sequence of 13-bit test patterns to a
// combinational gate model, waits SETTLE_CYCLES for it to settle, and
// compacts each 10-bit response into a 16-bit MISR signature.
// Optional macro GATE_TEST_SEQ_LFSR_EN selects a 13-bit maximal LFSR
// pattern source (seed 13'h0001) instead of the default binary counter.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned NUM_PATTERNS  = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  dut_out,
  output logic [12:0] dut_in,
  output logic        busy,
  output logic        done,
  output logic [12:0] pat_idx,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

`ifdef GATE_TEST_SEQ_LFSR_EN
  localparam logic [12:0] SEED = 13'h0001;
`else
  localparam logic [12:0] SEED = 13'h0000;
`endif

  localparam logic [12:0] LAST_IDX    = 13'(NUM_PATTERNS - 1);
  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  settle_cnt;
  logic [12:0] pat;
  logic [12:0] pat_next;
  logic [15:0] sig_next;
  logic        launch;
  logic        last_pat;

  // Pattern generator successor function
  always_comb begin
`ifdef GATE_TEST_SEQ_LFSR_EN
    pat_next = {pat[11:0], pat[12] ^ pat[3] ^ pat[2] ^ pat[0]};
`else
    pat_next = pat + 13'd1;
`endif
  end

  // MISR step folding the current response into the signature
  always_comb begin
    sig_next = {signature[14:0],
                signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
               ^ {6'b0, dut_out};
  end

  // Run-launch and end-of-run qualifiers
  always_comb begin
    launch   = ((state == S_IDLE) || (state == S_DONE)) && start;
    last_pat = (pat_idx == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nx = S_APPLY;
        S_APPLY:        state_nx = S_SETTLE;
        S_SETTLE:       if (settle_cnt <= 8'd1) state_nx = S_CAPTURE;
        S_CAPTURE:      state_nx = last_pat ? S_DONE : S_APPLY;
        default:        state_nx = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state
  always_comb begin
    busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CAPTURE);
    done = (state == S_DONE);
  end

  // Datapath: settle counter, pattern source, stimulus, index and MISR.
  // dut_in is loaded on the edge that enters APPLY (run launch or previous
  // CAPTURE) so the vector is already on the pins for the whole APPLY cycle
  // and stays put through SETTLE and CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      pat        <= SEED;
      dut_in     <= '0;
      pat_idx    <= '0;
      signature  <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (launch) begin
            signature <= '0;
            pat_idx   <= '0;
            pat       <= SEED;
            dut_in    <= SEED;
          end
        end
        S_APPLY: begin
          settle_cnt <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
        end
        S_CAPTURE: begin
          signature <= sig_next;
          if (!last_pat) begin
            pat_idx <= pat_idx + 13'd1;
            pat     <= pat_next;
            dut_in  <= pat_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Self-checking bench for gate_test_sequencer: three instances (full-size,
// mid-size, single-pattern) driven by directed and random stimulus and
// compared every cycle against a pattern-table / elapsed-time model.
module tb_gate_test_sequencer;

`ifdef GATE_TEST_SEQ_LFSR_EN
  localparam int unsigned BIG_N = 8191;
  localparam logic [12:0] SEED  = 13'h0001;
`else
  localparam int unsigned BIG_N = 8192;
  localparam logic [12:0] SEED  = 13'h0000;
`endif
  localparam int unsigned MID_N = 12;
  localparam int unsigned MID_S = 3;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [NI];
  logic        start_v [NI];
  logic        abort_v [NI];
  logic [9:0]  mask    [NI];
  logic [9:0]  dout    [NI];
  logic [12:0] din_o   [NI];
  logic [12:0] pidx_o  [NI];
  logic        busy_o  [NI];
  logic        done_o  [NI];
  logic [15:0] sig_o   [NI];

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc     = 0;

  // Response functions of the three gate models
  assign dout[0] = din_o[0][9:0] ^ mask[0];
  assign dout[1] = {din_o[1][2:0], din_o[1][12:6]} ^ mask[1];
  assign dout[2] = 10'h3FF ^ mask[2];

  gate_test_sequencer #(.SETTLE_CYCLES(2), .NUM_PATTERNS(BIG_N)) u_big (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .dut_out(dout[0]), .dut_in(din_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pat_idx(pidx_o[0]), .signature(sig_o[0]));

  gate_test_sequencer #(.SETTLE_CYCLES(MID_S), .NUM_PATTERNS(MID_N)) u_mid (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .dut_out(dout[1]), .dut_in(din_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pat_idx(pidx_o[1]), .signature(sig_o[1]));

  gate_test_sequencer #(.SETTLE_CYCLES(1), .NUM_PATTERNS(1)) u_small (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .dut_out(dout[2]), .dut_in(din_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .pat_idx(pidx_o[2]), .signature(sig_o[2]));

  // ---------------- reference model ----------------
  logic [12:0] pats [8192];

  initial begin
    logic [12:0] p;
    p = SEED;
    for (int k = 0; k < 8192; k++) begin
      pats[k] = p;
`ifdef GATE_TEST_SEQ_LFSR_EN
      p = {p[11:0], p[12] ^ p[3] ^ p[2] ^ p[0]};
`else
      p = p + 13'd1;
`endif
    end
  end

  typedef struct {
    bit          valid;
    bit          running;
    bit          fin;
    int unsigned el;
    int unsigned idx;
    logic [15:0] sig;
    logic [12:0] din;
  } mdl_t;

  mdl_t m [NI];

  function automatic int unsigned n_of(int i);
    case (i)
      0: return BIG_N;
      1: return MID_N;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned s_of(int i);
    case (i)
      0: return 2;
      1: return MID_S;
      default: return 1;
    endcase
  endfunction

  function automatic logic [9:0] fout(int i, logic [12:0] d);
    case (i)
      0: return d[9:0] ^ mask[0];
      1: return {d[2:0], d[12:6]} ^ mask[1];
      default: return 10'h3FF ^ mask[2];
    endcase
  endfunction

  function automatic logic [15:0] misr(logic [15:0] s, logic [9:0] d);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {6'b0, d};
  endfunction

  // One pattern occupies s+2 cycles; elapsed position el runs 0..s+1 and the
  // response is compacted on the last of them.
  function automatic mdl_t step(mdl_t s, int i);
    mdl_t r;
    r = s;
    if (rst_v[i]) begin
      r.valid = 1; r.running = 0; r.fin = 0; r.el = 0;
      r.idx = 0; r.sig = '0; r.din = '0;
    end else if (!r.valid) begin
      r.valid = 0;
    end else if (abort_v[i]) begin
      r.running = 0; r.fin = 0;
    end else if (r.running) begin
      if (r.el == s_of(i) + 1) begin
        r.sig = misr(r.sig, fout(i, r.din));
        if (r.idx == n_of(i) - 1) begin
          r.running = 0; r.fin = 1;
        end else begin
          r.idx = r.idx + 1; r.din = pats[r.idx]; r.el = 0;
        end
      end else begin
        r.el = r.el + 1;
      end
    end else if (start_v[i]) begin
      r.running = 1; r.fin = 0; r.el = 0; r.idx = 0;
      r.sig = '0; r.din = pats[0];
    end
    return r;
  endfunction

  initial for (int i = 0; i < NI; i++) m[i].valid = 0;

  // Advance the model and the cycle counter on every active edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) m[i] <= step(m[i], i);
  end

  task automatic check(input int inst, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL u%0d.%s got=%0h want=%0h @cyc %0d", inst, nm, act, exp, cyc);
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (m[i].valid) begin
        check(i, "busy",   32'(busy_o[i]), 32'(m[i].running));
        check(i, "done",   32'(done_o[i]), 32'(m[i].fin));
        check(i, "pidx",   32'(pidx_o[i]), m[i].idx);
        check(i, "sig",    32'(sig_o[i]),  32'(m[i].sig));
        check(i, "dut_in", 32'(din_o[i]),  32'(m[i].din));
      end
    end
  end

  task automatic wait_done(input int i, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (done_o[i] !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(i, "done_reached", 32'(done_o[i]), 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int unsigned t0;
    logic [15:0] sig1;
    logic [12:0] exp4 [4];
`ifdef GATE_TEST_SEQ_LFSR_EN
    exp4 = '{13'h0001, 13'h0003, 13'h0007, 13'h000E};
`else
    exp4 = '{13'h0000, 13'h0001, 13'h0002, 13'h0003};
`endif
    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1; start_v[i] = 1'b0; abort_v[i] = 1'b0; mask[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check(i, "rst.busy", 32'(busy_o[i]), 32'd0);
      check(i, "rst.done", 32'(done_o[i]), 32'd0);
      check(i, "rst.din",  32'(din_o[i]),  32'd0);
      check(i, "rst.pidx", 32'(pidx_o[i]), 32'd0);
      check(i, "rst.sig",  32'(sig_o[i]),  32'd0);
    end

    // Single pattern, single settle cycle, all-ones response
    start_v[2] = 1'b1;
    @(negedge clk); start_v[2] = 1'b0;
    check(2, "a.apply_busy", 32'(busy_o[2]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check(2, "a.capture_done", 32'(done_o[2]), 32'd0);
    @(negedge clk);
    check(2, "a.done",  32'(done_o[2]), 32'd1);
    check(2, "a.busy",  32'(busy_o[2]), 32'd0);
    check(2, "a.sig",   32'(sig_o[2]),  32'h03FF);
    check(2, "a.model_sig", 32'(m[2].sig), 32'h03FF);
    check(2, "a.model_pat3", 32'(pats[3]), 32'(exp4[3]));

    // Pattern order, run length, and a rerun from DONE
    mask[1] = 10'h2A5;
    start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0; t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      check(1, "b.seq_din", 32'(din_o[1]), 32'(exp4[k]));
      repeat (MID_S + 2) @(negedge clk);
    end
    wait_done(1, 200);
    check(1, "b.cycles", cyc - t0, MID_N * (MID_S + 2));
    check(1, "b.pidx", 32'(pidx_o[1]), MID_N - 1);
    sig1 = m[1].sig;
    repeat (3) @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0; t0 = cyc;
    check(1, "b2.sig_clr", 32'(sig_o[1]), 32'd0);
    check(1, "b2.pidx_clr", 32'(pidx_o[1]), 32'd0);
    check(1, "b2.din_seed", 32'(din_o[1]), 32'(SEED));
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      start_v[1] = (j % 3 == 0);
    end
    start_v[1] = 1'b0;
    wait_done(1, 200);
    check(1, "b2.cycles", cyc - t0, MID_N * (MID_S + 2));
    check(1, "b2.sig_same", 32'(sig_o[1]), 32'(sig1));

    // Abort at pattern 5 of a full-size run, then restart
    mask[0] = 10'h155;
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (5 * 4) @(negedge clk);
    check(0, "c.pidx_pre", 32'(pidx_o[0]), 32'd5);
    abort_v[0] = 1'b1;
    @(negedge clk); abort_v[0] = 1'b0;
    check(0, "c.busy", 32'(busy_o[0]), 32'd0);
    check(0, "c.done", 32'(done_o[0]), 32'd0);
    check(0, "c.pidx", 32'(pidx_o[0]), 32'd5);
    repeat (3) @(negedge clk);
    check(0, "c.done_idle", 32'(done_o[0]), 32'd0);
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    check(0, "c.sig_clr", 32'(sig_o[0]), 32'd0);
    check(0, "c.din_seed", 32'(din_o[0]), 32'(SEED));
    check(0, "c.pidx_clr", 32'(pidx_o[0]), 32'd0);
    repeat (9) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk); abort_v[0] = 1'b0;
    check(0, "c.busy2", 32'(busy_o[0]), 32'd0);

    // Reset in the middle of a run
    start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    repeat (17) @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk); rst_v[1] = 1'b0;
    check(1, "r.busy", 32'(busy_o[1]), 32'd0);
    check(1, "r.done", 32'(done_o[1]), 32'd0);
    check(1, "r.din",  32'(din_o[1]),  32'd0);
    check(1, "r.pidx", 32'(pidx_o[1]), 32'd0);
    check(1, "r.sig",  32'(sig_o[1]),  32'd0);
    repeat (5) @(negedge clk);
    check(1, "r.no_done", 32'(done_o[1]), 32'd0);

    // Complete full-size run with dut_out = dut_in[9:0]
    mask[0] = '0;
    start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; t0 = cyc;
    wait_done(0, BIG_N * 4 + 20);
    check(0, "d.cycles", cyc - t0, BIG_N * 4);
    check(0, "d.pidx", 32'(pidx_o[0]), BIG_N - 1);
`ifdef GATE_TEST_SEQ_LFSR_EN
    check(0, "d.din_last", 32'(din_o[0]), 32'(pats[BIG_N - 1]));
`else
    check(0, "d.din_last", 32'(din_o[0]), 32'h1FFF);
`endif

    // Random start/abort/reset/response traffic on the small instances
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 1; i < NI; i++) begin
        start_v[i] = ($urandom_range(0, 5) == 0);
        abort_v[i] = ($urandom_range(0, 40) == 0);
        rst_v[i]   = ($urandom_range(0, 300) == 0);
        if ($urandom_range(0, 20) == 0) mask[i] = 10'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; abort_v[i] = 1'b0; rst_v[i] = 1'b0;
    end
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
